// File: rtl/dffn_lc_pkg.sv
// Shared types and constants for the negedge-chain launch/capture engine.
package dffn_lc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } lc_state_e;

    // PRBS7 polynomial x^7 + x^6 + 1: feedback from bits 6 and 5.
    localparam int PRBS_TAP_A = 6;
    localparam int PRBS_TAP_B = 5;

    localparam logic [6:0] PRBS_DEFAULT_SEED = 7'h01;

    // One PRBS7 step: shift left, feedback into bit 0.
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
    endfunction

    // The all-zero state is a lock-up state, so it is replaced by the default seed.
    function automatic logic [6:0] prbs7_fix_seed(input logic [6:0] s);
        return (s == 7'h00) ? PRBS_DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/dffn_lc_prbs7.sv
// PRBS7 generator: load restarts from SEED, step advances one state,
// prbs_bit is the bit that the next launch will drive.
module dffn_lc_prbs7
    import dffn_lc_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h01
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic step,
    output logic prbs_bit
);

    localparam logic [6:0] SEED_EFF = prbs7_fix_seed(SEED);

    logic [6:0] lfsr_r;

    // LFSR state; load+step together means the seed bit is consumed on this edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr_r <= SEED_EFF;
        end else if (load) begin
            lfsr_r <= step ? prbs7_next(SEED_EFF) : SEED_EFF;
        end else if (step) begin
            lfsr_r <= prbs7_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign prbs_bit = lfsr_r[PRBS_TAP_A];

endmodule

// File: rtl/dffn_launch_capture.sv
// Launch/capture engine for a chain of negedge D flip-flops: launches PRBS7
// bits on rising edges, compares the chain output DEPTH edges later, and
// reports a mismatch count and pass flag.
module dffn_launch_capture
    import dffn_lc_pkg::*;
#(
    parameter int         DEPTH = 1,
    parameter int         CNT_W = 16,
    parameter logic [6:0] SEED  = 7'h01
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [CNT_W-1:0] LEN,
    input  logic             Q_IN,
    output logic             D_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             PASS
);

    localparam logic [6:0]       SEED_EFF   = prbs7_fix_seed(SEED);
    localparam int               DRAIN_W    = $clog2(DEPTH + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DEPTH);
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO = {DRAIN_W{1'b0}};
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = {{(DRAIN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    lc_state_e          state_r;
    lc_state_e          state_nxt_s;
    logic [CNT_W-1:0]   launch_cnt_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [DEPTH-1:0]   exp_pipe_r;
    logic [DEPTH-1:0]   vld_pipe_r;
    logic [DEPTH-1:0]   exp_pipe_nxt_s;
    logic [DEPTH-1:0]   vld_pipe_nxt_s;
    logic               d_out_r;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   err_cnt_r;
    logic               pass_r;

    logic               prbs_bit_s;
    logic               len_zero_s;
    logic               start_run_s;
    logic               start_empty_s;
    logic               launch_s;
    logic               launch_bit_s;
    logic               run_end_s;
    logic               mismatch_s;

    assign len_zero_s = (LEN == CNT_ZERO);

    // The bit leaving the expected pipe lines up with the chain output on this edge.
    assign mismatch_s = vld_pipe_r[DEPTH-1] & (Q_IN ^ exp_pipe_r[DEPTH-1]);

    dffn_lc_prbs7 #(
        .SEED (SEED_EFF)
    ) u_prbs (
        .CLK      (CLK),
        .RST      (RST),
        .load     (start_run_s),
        .step     (launch_s),
        .prbs_bit (prbs_bit_s)
    );

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a one-bit run launches only on the START edge, so it skips RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (START && !len_zero_s) begin
                    state_nxt_s = (LEN == CNT_ONE) ? DRAIN : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (launch_cnt_r == CNT_ONE) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_ZERO) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM decoded controls: which bit is launched and when a run begins or ends.
    always_comb begin
        start_run_s   = 1'b0;
        start_empty_s = 1'b0;
        launch_s      = 1'b0;
        launch_bit_s  = 1'b0;
        run_end_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (START && len_zero_s) begin
                    start_empty_s = 1'b1;
                end else if (START) begin
                    start_run_s  = 1'b1;
                    launch_s     = 1'b1;
                    launch_bit_s = SEED_EFF[PRBS_TAP_A];
                end else begin
                    start_run_s = 1'b0;
                end
            end
            RUN: begin
                launch_s     = 1'b1;
                launch_bit_s = prbs_bit_s;
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_ZERO) begin
                    run_end_s = 1'b1;
                end else begin
                    run_end_s = 1'b0;
                end
            end
            default: begin
                run_end_s = 1'b0;
            end
        endcase
    end

    // Launch counter holds the launches still to go; drain counter the compare cycles left.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            launch_cnt_r <= CNT_ZERO;
            drain_cnt_r  <= DRAIN_ZERO;
        end else begin
            if (start_run_s) begin
                launch_cnt_r <= LEN - CNT_ONE;
            end else if (state_r == RUN) begin
                launch_cnt_r <= launch_cnt_r - CNT_ONE;
            end else begin
                launch_cnt_r <= launch_cnt_r;
            end
            if ((state_r != DRAIN) && (state_nxt_s == DRAIN)) begin
                drain_cnt_r <= DRAIN_LOAD;
            end else if ((state_r == DRAIN) && (drain_cnt_r != DRAIN_ZERO)) begin
                drain_cnt_r <= drain_cnt_r - DRAIN_ONE;
            end else begin
                drain_cnt_r <= drain_cnt_r;
            end
        end
    end

    // Next values of the expected-bit and valid pipes (stage 0 takes this edge's launch).
    always_comb begin
        exp_pipe_nxt_s    = exp_pipe_r;
        vld_pipe_nxt_s    = vld_pipe_r;
        exp_pipe_nxt_s[0] = launch_bit_s;
        vld_pipe_nxt_s[0] = launch_s;
        for (int i = 1; i < DEPTH; i++) begin
            exp_pipe_nxt_s[i] = exp_pipe_r[i-1];
            vld_pipe_nxt_s[i] = vld_pipe_r[i-1];
        end
    end

    // Expected-bit and valid pipes, DEPTH deep to match the chain latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exp_pipe_r <= {DEPTH{1'b0}};
            vld_pipe_r <= {DEPTH{1'b0}};
        end else begin
            exp_pipe_r <= exp_pipe_nxt_s;
            vld_pipe_r <= vld_pipe_nxt_s;
        end
    end

    // Registered outputs: launch data, status flags and the mismatch counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d_out_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_cnt_r <= CNT_ZERO;
            pass_r    <= 1'b0;
        end else begin
            d_out_r <= launch_bit_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= run_end_s | start_empty_s;
            if (start_run_s || start_empty_s) begin
                err_cnt_r <= CNT_ZERO;
            end else if (mismatch_s) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
            if (start_run_s) begin
                pass_r <= 1'b0;
            end else if (start_empty_s) begin
                pass_r <= 1'b1;
            end else if (run_end_s) begin
                pass_r <= (err_cnt_r == CNT_ZERO) && !mismatch_s;
            end else begin
                pass_r <= pass_r;
            end
        end
    end

    assign D_OUT   = d_out_r;
    assign BUSY    = busy_r;
    assign DONE    = done_r;
    assign ERR_CNT = err_cnt_r;
    assign PASS    = pass_r;

endmodule

// File: tb/tb_dffn_launch_capture.sv
// Bench for dffn_launch_capture: two instances (DEPTH=1, DEPTH=4 with a zero
// seed that must fall back to 7'h01) each looped through ideal negedge flops.
module tb_dffn_launch_capture;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start_s [2];
    logic [15:0] len_s   [2];
    logic        q_in_s  [2];
    logic        d_out_s [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [15:0] err_s   [2];
    logic        pass_s  [2];
    int          qmode_s [2];
    logic        flip_s  [2];
    logic        chain1_r;
    logic [3:0]  chain4_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    dffn_launch_capture #(.DEPTH(1), .CNT_W(16), .SEED(7'h01)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(start_s[0]), .LEN(len_s[0]), .Q_IN(q_in_s[0]),
        .D_OUT(d_out_s[0]), .BUSY(busy_s[0]), .DONE(done_s[0]), .ERR_CNT(err_s[0]), .PASS(pass_s[0])
    );

    dffn_launch_capture #(.DEPTH(4), .CNT_W(16), .SEED(7'h00)) u_dut4 (
        .CLK(CLK), .RST(RST), .START(start_s[1]), .LEN(len_s[1]), .Q_IN(q_in_s[1]),
        .D_OUT(d_out_s[1]), .BUSY(busy_s[1]), .DONE(done_s[1]), .ERR_CNT(err_s[1]), .PASS(pass_s[1])
    );

    // Ideal negedge flop chains standing in for the cells under test.
    always @(negedge CLK or posedge RST) begin
        if (RST) begin
            chain1_r <= 1'b0;
            chain4_r <= 4'd0;
        end else begin
            chain1_r <= d_out_s[0];
            chain4_r <= {chain4_r[2:0], d_out_s[1]};
        end
    end

    // Q_IN source: 0 = loopback (optionally corrupted), 1 = stuck at 0, 2 = stuck at 1.
    always_comb begin
        q_in_s[0] = (qmode_s[0] == 1) ? 1'b0 : (qmode_s[0] == 2) ? 1'b1 : (chain1_r ^ flip_s[0]);
        q_in_s[1] = (qmode_s[1] == 1) ? 1'b0 : (qmode_s[1] == 2) ? 1'b1 : (chain4_r[3] ^ flip_s[1]);
    end

    // Reference PRBS7 (x^7+x^6+1, seed 1): bit k of the launched sequence.
    function automatic logic prbs_ref(input int k);
        int s;
        s = 1;
        for (int j = 0; j < k; j++) begin
            s = ((s << 1) | (((s >> 6) ^ (s >> 5)) & 1)) & 127;
        end
        return ((s >> 6) & 1) != 0;
    endfunction

    // One run on instance idx, checked every cycle against the reference model.
    task automatic run_scenario(input int idx, input int len, input int qmode, input bit use_flips,
                                input int restart_at, input string name, output int busy_cnt);
        int   depth, last_e, exp_err, done_seen;
        logic fl, b, mism, exp_d, exp_busy, exp_done, exp_pass;
        depth     = (idx == 0) ? 1 : 4;
        last_e    = (len == 0) ? 0 : len + depth;
        exp_err   = 0;
        done_seen = 0;
        busy_cnt  = 0;
        @(negedge CLK);
        qmode_s[idx] = qmode;
        flip_s[idx]  = 1'b0;
        len_s[idx]   = 16'(len);
        start_s[idx] = 1'b1;
        for (int e = 0; e <= last_e + 2; e++) begin
            fl = 1'b0;
            if (e > 0) begin
                @(negedge CLK);
                start_s[idx] = (e == restart_at);
                if (e == restart_at) len_s[idx] = 16'd3;
                fl = use_flips && ($urandom_range(0, 7) == 0);
                flip_s[idx] = fl;
            end
            @(posedge CLK);
            #1;
            if (len != 0 && e >= depth && e < len + depth) begin
                b    = prbs_ref(e - depth);
                mism = (qmode == 0) ? fl : (qmode == 1) ? b : !b;
                if (mism) exp_err++;
            end
            exp_d    = (len != 0 && e < len) ? prbs_ref(e) : 1'b0;
            exp_busy = (len != 0 && e < len + depth);
            exp_done = (e == last_e);
            exp_pass = (e >= last_e) ? (exp_err == 0) : 1'b0;
            if (d_out_s[idx] !== exp_d) begin
                n_fail++; $display("FAIL %s d_out edge %0d: got %b expected %b", name, e, d_out_s[idx], exp_d);
            end
            n_checks++;
            if (busy_s[idx] !== exp_busy) begin
                n_fail++; $display("FAIL %s busy edge %0d: got %b expected %b", name, e, busy_s[idx], exp_busy);
            end
            n_checks++;
            if (done_s[idx] !== exp_done) begin
                n_fail++; $display("FAIL %s done edge %0d: got %b expected %b", name, e, done_s[idx], exp_done);
            end
            n_checks++;
            if (err_s[idx] !== 16'(exp_err)) begin
                n_fail++; $display("FAIL %s err_cnt edge %0d: got %0d expected %0d", name, e, err_s[idx], exp_err);
            end
            n_checks++;
            if (pass_s[idx] !== exp_pass) begin
                n_fail++; $display("FAIL %s pass edge %0d: got %b expected %b", name, e, pass_s[idx], exp_pass);
            end
            n_checks++;
            if (busy_s[idx] === 1'b1) busy_cnt++;
            if (done_s[idx] === 1'b1) done_seen++;
        end
        if (done_seen !== 1) begin
            n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_seen);
        end
        n_checks++;
        flip_s[idx]  = 1'b0;
        start_s[idx] = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            if ({d_out_s[i], busy_s[i], done_s[i], pass_s[i]} !== 4'b0000 || err_s[i] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got d=%b busy=%b done=%b pass=%b err=%0d expected all 0",
                         i, d_out_s[i], busy_s[i], done_s[i], pass_s[i], err_s[i]);
            end
            n_checks++;
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_seed_len7();
        int bc;
        run_scenario(0, 7, 0, 1'b0, -1, "seed1_len7", bc);
        if (bc !== 8 || pass_s[0] !== 1'b1 || err_s[0] !== 16'd0) begin
            n_fail++; $display("FAIL seed1_len7 summary: busy=%0d pass=%b err=%0d expected 8 1 0", bc, pass_s[0], err_s[0]);
        end
        n_checks++;
    endtask

    task automatic test_stuck();
        int bc;
        run_scenario(0, 7, 1, 1'b0, -1, "stuck0", bc);
        if (err_s[0] !== 16'd1 || pass_s[0] !== 1'b0) begin
            n_fail++; $display("FAIL stuck0 result: err=%0d pass=%b expected 1 0", err_s[0], pass_s[0]);
        end
        n_checks++;
        run_scenario(0, 7, 2, 1'b0, -1, "stuck1", bc);
        if (err_s[0] !== 16'd6 || pass_s[0] !== 1'b0) begin
            n_fail++; $display("FAIL stuck1 result: err=%0d pass=%b expected 6 0", err_s[0], pass_s[0]);
        end
        n_checks++;
    endtask

    task automatic test_depth4();
        int bc;
        run_scenario(1, 100, 0, 1'b0, -1, "depth4_len100", bc);
        if (bc !== 104 || err_s[1] !== 16'd0 || pass_s[1] !== 1'b1) begin
            n_fail++; $display("FAIL depth4_len100 summary: busy=%0d err=%0d pass=%b expected 104 0 1", bc, err_s[1], pass_s[1]);
        end
        n_checks++;
    endtask

    task automatic test_len_zero();
        int bc;
        run_scenario(0, 0, 0, 1'b0, -1, "len0", bc);
        if (bc !== 0 || pass_s[0] !== 1'b1) begin
            n_fail++; $display("FAIL len0 summary: busy=%0d pass=%b expected 0 1", bc, pass_s[0]);
        end
        n_checks++;
    endtask

    task automatic test_back_to_back_start();
        int bc;
        run_scenario(0, 20, 0, 1'b1, 3, "restart_ignored", bc);
        if (bc !== 21) begin
            n_fail++; $display("FAIL restart_ignored busy_cycles: got %0d expected 21", bc);
        end
        n_checks++;
    endtask

    task automatic test_rst_midrun();
        int bc, dones;
        @(negedge CLK);
        qmode_s[0] = 0;
        len_s[0]   = 16'd50;
        start_s[0] = 1'b1;
        @(posedge CLK);
        #1;
        start_s[0] = 1'b0;
        repeat (4) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        if ({d_out_s[0], busy_s[0], done_s[0], pass_s[0]} !== 4'b0000 || err_s[0] !== 16'd0) begin
            n_fail++; $display("FAIL rst_midrun outputs: d=%b busy=%b done=%b pass=%b err=%0d expected all 0",
                               d_out_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0]);
        end
        n_checks++;
        dones = 0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (done_s[0] === 1'b1) dones++;
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
            if (done_s[0] === 1'b1 || busy_s[0] === 1'b1) dones++;
        end
        if (dones !== 0) begin
            n_fail++; $display("FAIL rst_midrun no_done: got %0d done/busy samples expected 0", dones);
        end
        n_checks++;
        run_scenario(0, 7, 0, 1'b0, -1, "after_rst", bc);
    endtask

    task automatic test_random();
        int bc;
        for (int it = 0; it < 12; it++) begin
            run_scenario($urandom_range(0, 1), $urandom_range(0, 40), $urandom_range(0, 2),
                         1'b1, -1, "random", bc);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            len_s[i]   = 16'd0;
            qmode_s[i] = 0;
            flip_s[i]  = 1'b0;
        end
        test_reset();
        test_seed_len7();
        test_stuck();
        test_depth4();
        test_len_zero();
        test_back_to_back_start();
        test_rst_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
